checksum_engine: RTL and testbench

Multi-channel, parametrised successor of the single-channel checksum accelerator on the HPS lightweight Avalon-MM bridge. Software starts a job on one of NUM_CH channels with a word count, streams data words into that channel's data window, and gets a maskable interrupt per channel when the programmed count has been accumulated. Each data word is reduced lane-wise in a two-stage pipeline, so the bus sustains one write per cycle.

---
 rtl/checksum_pkg.sv | 55 +++++
 rtl/checksum_lane_adder.sv | 27 ++
 rtl/checksum_engine.sv | 155 +++++++++++++++
 tb/tb_checksum_engine.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/checksum_pkg.sv
// checksum_pkg
// Shared definitions for the multi-channel checksum engine.
//   - reg_sel_e : control-window register selects (START, STATUS, IRQ_EN, ACC)
//   - ch_bits() : number of address bits used for the channel index
//   - add_acc() : ACC_W-wide addition used by both the lane reduction and the
//                 per-channel accumulators
// Build option: CHECKSUM_FOLD_EN turns every addition into an end-around-carry
// (ones'-complement) addition. When it is left undefined, carries are dropped.
package checksum_pkg;

    // Widest accumulator/lane width that add_acc can handle.
    localparam int MAX_W  = 64;
    localparam int MAX_W1 = MAX_W + 1;

    typedef enum logic [1:0] {
        SEL_START  = 2'd0,
        SEL_STATUS = 2'd1,
        SEL_IRQ_EN = 2'd2,
        SEL_ACC    = 2'd3
    } reg_sel_e;

    // A single channel still uses one index bit so the address fields never
    // collapse to zero width.
    function automatic int ch_bits(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    // Operands arrive zero-extended to MAX_W. Only the low w bits of the
    // result are meaningful; callers truncate to their own width.
    function automatic logic [MAX_W-1:0] add_acc(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] sum;
`ifdef CHECKSUM_FOLD_EN
        logic [MAX_W:0] full;
        logic [MAX_W:0] carry_bit;
`endif
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
`ifdef CHECKSUM_FOLD_EN
        full      = {1'b0, a} + {1'b0, b};
        carry_bit = MAX_W1'(1) << w;
        sum       = full[MAX_W-1:0] & mask;
        // The carry out of bit w-1 wraps back into bit 0. With both operands
        // below 2^w, this second addition can never carry again.
        if ((full & carry_bit) != '0) begin
            sum = (sum + MAX_W'(1)) & mask;
        end
`else
        sum = (a + b) & mask;
`endif
        return sum;
    endfunction

endpackage

// File: rtl/checksum_lane_adder.sv
// checksum_lane_adder
// Combinational reduction of one DATA_W data word into an ACC_W lane sum.
// The word is split into DATA_W/ACC_W lanes, and the lanes are added with
// add_acc. As a result, the CHECKSUM_FOLD_EN build option applies here as well.
// Ports:
//   data  in  DATA_W  data word to reduce
//   sum   out ACC_W   sum of all lanes
module checksum_lane_adder
    import checksum_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ACC_W  = 32
) (
    input  logic [DATA_W-1:0] data,
    output logic [ACC_W-1:0]  sum
);

    localparam int LANES = DATA_W / ACC_W;

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = ACC_W'(add_acc(MAX_W'(sum), MAX_W'(data[i*ACC_W +: ACC_W]), ACC_W));
        end
    end

endmodule

// File: rtl/checksum_engine.sv
// checksum_engine
// Multi-channel checksum accelerator on an Avalon-MM slave port. Software
// writes START with a word count, then streams data words into the channel's
// data window. Each word is first reduced lane-wise and registered (stage 1).
// The lane sum is then added into the channel accumulator (stage 2). When the
// count is used up, the engine sets the channel's done flag, and irq is raised
// for each channel whose done flag and irq enable are both set.
// Build option: CHECKSUM_FOLD_EN selects ones'-complement addition.
// Ports:
//   clk        in  1       rising-edge clock
//   reset      in  1       synchronous, active-high
//   address    in  ADDR_W  word address (MSB=1 control window, 0 data window)
//   write      in  1       write strobe
//   writedata  in  DATA_W  write data
//   read       in  1       read strobe
//   readdata   out DATA_W  registered read data, latency 1
//   irq        out 1       registered level interrupt
module checksum_engine
    import checksum_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ACC_W  = 32,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic              read,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    localparam int CH_BITS = ch_bits(NUM_CH);

    logic [ACC_W-1:0]   acc [NUM_CH];
    logic [31:0]        cnt [NUM_CH];
    logic [NUM_CH-1:0]  busy;
    logic [NUM_CH-1:0]  done;
    logic [NUM_CH-1:0]  irq_en;

    logic               s1_valid;
    logic [CH_BITS-1:0] s1_ch;
    logic [ACC_W-1:0]   s1_sum;

    logic               is_ctrl;
    reg_sel_e           sel;
    logic [CH_BITS-1:0] ch;
    logic               ch_ok;
    logic               data_wr;
    logic               ctrl_wr;
    logic               start_wr;
    logic               kill;
    logic               s2_go;
    logic [ACC_W-1:0]   lane_sum;
    logic [ACC_W-1:0]   acc_sum;
    logic [DATA_W-1:0]  rd_value;

    checksum_lane_adder #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_lane_adder (
        .data (writedata),
        .sum  (lane_sum)
    );

    // Address decode and per-cycle qualifiers. Data words for idle channels
    // never enter the pipeline. A START on a channel cancels that channel's
    // entry in stage 1, so the old job cannot change the new job's acc or cnt.
    always_comb begin
        is_ctrl  = address[ADDR_W-1];
        sel      = reg_sel_e'(address[CH_BITS+1:CH_BITS]);
        ch       = address[CH_BITS-1:0];
        ch_ok    = (int'(ch) < NUM_CH);
        data_wr  = write && !is_ctrl && ch_ok && busy[ch];
        ctrl_wr  = write && is_ctrl && ch_ok;
        start_wr = ctrl_wr && (sel == SEL_START);
        kill     = start_wr && (s1_ch == ch);
        // A second word can reach stage 2 after the first word has used up
        // the count. The busy check drops that word here.
        s2_go    = s1_valid && busy[s1_ch] && !kill;
        acc_sum  = ACC_W'(add_acc(MAX_W'(acc[s1_ch]), MAX_W'(s1_sum), ACC_W));
    end

    // Read mux. Data-window reads, out-of-range channels and idle cycles all
    // return zero. Narrow fields are zero-extended to DATA_W.
    always_comb begin
        rd_value = '0;
        if (read && is_ctrl && ch_ok) begin
            case (sel)
                SEL_START:  rd_value = DATA_W'(cnt[ch]);
                SEL_STATUS: rd_value = DATA_W'({done[ch], busy[ch]});
                SEL_IRQ_EN: rd_value = DATA_W'(irq_en[ch]);
                SEL_ACC:    rd_value = DATA_W'(acc[ch]);
                default:    rd_value = '0;
            endcase
        end
    end

    // Register updates. The statement order sets priority: a W1C clear comes
    // before any done-set, so a set in the same cycle wins. START updates come
    // last. Stage 2 only ever writes to a channel that START is not touching
    // this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            busy     <= '0;
            done     <= '0;
            irq_en   <= '0;
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_sum   <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            s1_valid <= data_wr;
            s1_ch    <= ch;
            s1_sum   <= lane_sum;

            if (ctrl_wr && (sel == SEL_STATUS) && writedata[0]) begin
                done[ch] <= 1'b0;
            end
            if (ctrl_wr && (sel == SEL_IRQ_EN)) begin
                irq_en[ch] <= writedata[0];
            end

            if (s2_go) begin
                acc[s1_ch] <= acc_sum;
                cnt[s1_ch] <= cnt[s1_ch] - 32'd1;
                if (cnt[s1_ch] == 32'd1) begin
                    busy[s1_ch] <= 1'b0;
                    done[s1_ch] <= 1'b1;
                end
            end

            if (start_wr) begin
                cnt[ch]  <= writedata[31:0];
                acc[ch]  <= '0;
                busy[ch] <= (writedata[31:0] != 32'd0);
                if (writedata[31:0] == 32'd0) begin
                    done[ch] <= 1'b1;
                end
            end

            readdata <= rd_value;
            irq      <= |(done & irq_en);
        end
    end

endmodule

// File: tb/tb_checksum_engine.sv
// tb_checksum_engine
// Self-checking bench for checksum_engine with default parameters. It runs a
// table of directed vectors, hand-written multi-cycle corner cases, and then
// randomized operations checked against a transaction-level model. The bench
// also honours CHECKSUM_FOLD_EN when that macro is defined.
module tb_checksum_engine;

    localparam int DATA_W  = 64;
    localparam int ACC_W   = 32;
    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 10;
    localparam int CH_BITS = 2;

    localparam int R_START  = 0;
    localparam int R_STATUS = 1;
    localparam int R_IRQ_EN = 2;
    localparam int R_ACC    = 3;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              irq;

    int n_vectors     = 0;
    int n_miscompares = 0;

    checksum_engine #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .read      (read),
        .readdata  (readdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------
    logic [31:0] m_acc  [NUM_CH];
    logic [31:0] m_cnt  [NUM_CH];
    bit          m_busy [NUM_CH];
    bit          m_done [NUM_CH];
    bit          m_en   [NUM_CH];

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        longint unsigned s;
        s = longint'(a) + longint'(b);
`ifdef CHECKSUM_FOLD_EN
        s = (s & 64'hFFFF_FFFF) + (s >> 32);
`endif
        return s[31:0];
    endfunction

    function automatic logic [31:0] ref_word(input logic [63:0] d);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < DATA_W / ACC_W; i++) s = ref_add(s, d[i*32 +: 32]);
        return s;
    endfunction

    function automatic bit ref_irq();
        bit r;
        r = 1'b0;
        for (int i = 0; i < NUM_CH; i++) r |= (m_done[i] & m_en[i]);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] = '0; m_cnt[i] = '0; m_busy[i] = 0; m_done[i] = 0; m_en[i] = 0;
        end
    endfunction

    // ---------------- bus helpers ----------------
    function automatic logic [ADDR_W-1:0] ctrl_addr(input int sel, input int ch);
        return ADDR_W'((1 << (ADDR_W - 1)) | (sel << CH_BITS) | ch);
    endfunction

    function automatic logic [ADDR_W-1:0] data_addr(input int ch);
        return ADDR_W'(ch);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // All bus tasks start at a falling edge and return one falling edge later.
    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [63:0] d);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_reg(input string name, input int sel, input int ch,
                             input logic [63:0] expected);
        logic [63:0] rd;
        bus_read(ctrl_addr(sel, ch), rd);
        checkOutput(name, rd, expected);
    endtask

    task automatic check_all_zero(input string tag);
        logic [63:0] rd;
        checkOutput({tag, "_irq"}, 64'(irq), 64'd0);
        checkOutput({tag, "_readdata"}, readdata, 64'd0);
        for (int c = 0; c < NUM_CH; c++) begin
            check_reg($sformatf("%s_status%0d", tag, c), R_STATUS, c, 64'd0);
            check_reg($sformatf("%s_acc%0d", tag, c), R_ACC, c, 64'd0);
            check_reg($sformatf("%s_irqen%0d", tag, c), R_IRQ_EN, c, 64'd0);
            check_reg($sformatf("%s_cnt%0d", tag, c), R_START, c, 64'd0);
        end
        bus_read(data_addr(0), rd);
        checkOutput({tag, "_datawin_rd"}, rd, 64'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef enum int {OP_WR_CTRL, OP_WR_DATA, OP_RD_CTRL, OP_CHK_IRQ} op_e;

    typedef struct {
        op_e         op;
        int          sel;
        int          ch;
        logic [63:0] data;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [14];

    task automatic applyStimulus(input vec_t v);
        logic [63:0] rd;
        case (v.op)
            OP_WR_CTRL: bus_write(ctrl_addr(v.sel, v.ch), v.data);
            OP_WR_DATA: bus_write(data_addr(v.ch), v.data);
            OP_RD_CTRL: begin
                bus_read(ctrl_addr(v.sel, v.ch), rd);
                checkOutput(v.name, rd, v.exp);
            end
            OP_CHK_IRQ: checkOutput(v.name, 64'(irq), v.exp);
            default: ;
        endcase
        idle(3);
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] d;
        int          ch;
        int          kind;
        int          sel;
        logic [31:0] count;
        logic [63:0] exp;

        reset = 1'b1; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
        model_reset();
        idle(2);
        reset = 1'b0;
        $display("[TB] reset state");
        check_all_zero("reset");

        // Basic job on channel 1 with interrupt enable and W1C.
        vecs[0]  = '{OP_WR_CTRL, R_START,  1, 64'd2,                     64'd0,  "t1_start"};
        vecs[1]  = '{OP_RD_CTRL, R_STATUS, 1, 64'd0,                     64'd1,  "t1_status_busy"};
        vecs[2]  = '{OP_WR_DATA, 0,        1, 64'h00000002_00000003,     64'd0,  "t1_wr0"};
        vecs[3]  = '{OP_WR_DATA, 0,        1, 64'h00000010_00000000,     64'd0,  "t1_wr1"};
        vecs[4]  = '{OP_RD_CTRL, R_ACC,    1, 64'd0,                     64'h15, "t1_acc"};
        vecs[5]  = '{OP_RD_CTRL, R_STATUS, 1, 64'd0,                     64'd2,  "t1_status_done"};
        vecs[6]  = '{OP_RD_CTRL, R_START,  1, 64'd0,                     64'd0,  "t1_cnt"};
        vecs[7]  = '{OP_CHK_IRQ, 0,        0, 64'd0,                     64'd0,  "t1_irq_masked"};
        vecs[8]  = '{OP_WR_CTRL, R_IRQ_EN, 1, 64'd1,                     64'd0,  "t1_irqen_wr"};
        vecs[9]  = '{OP_CHK_IRQ, 0,        0, 64'd0,                     64'd1,  "t1_irq_on"};
        vecs[10] = '{OP_RD_CTRL, R_IRQ_EN, 1, 64'd0,                     64'd1,  "t1_irqen_rd"};
        vecs[11] = '{OP_WR_CTRL, R_STATUS, 1, 64'd1,                     64'd0,  "t1_w1c"};
        vecs[12] = '{OP_CHK_IRQ, 0,        0, 64'd0,                     64'd0,  "t1_irq_off"};
        vecs[13] = '{OP_RD_CTRL, R_STATUS, 1, 64'd0,                     64'd0,  "t1_status_clr"};
        $display("[TB] directed vector table");
        for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

        // Lane and accumulator addition with wrap-around carries.
        $display("[TB] carry handling");
        do_reset();
        bus_write(ctrl_addr(R_START, 0), 64'd1);
        bus_write(data_addr(0), 64'hFFFFFFFF_00000001);
        idle(3);
`ifdef CHECKSUM_FOLD_EN
        exp = 64'h1;
`else
        exp = 64'h0;
`endif
        check_reg("fold_acc", R_ACC, 0, exp);

        // Zero-count START: done on the next cycle, irq on the cycle after.
        $display("[TB] zero-count start");
        do_reset();
        bus_write(ctrl_addr(R_IRQ_EN, 2), 64'd1);
        idle(2);
        bus_write(ctrl_addr(R_START, 2), 64'd0);
        checkOutput("zc_irq_t1", 64'(irq), 64'd0);
        bus_read(ctrl_addr(R_STATUS, 2), rd);
        checkOutput("zc_done_t1", rd, 64'd2);
        checkOutput("zc_irq_t2", 64'(irq), 64'd1);
        check_reg("zc_acc", R_ACC, 2, 64'd0);

        // START on a channel that still has a word in flight.
        $display("[TB] start over in-flight data");
        do_reset();
        bus_write(ctrl_addr(R_START, 3), 64'd1);
        idle(2);
        bus_write(data_addr(3), 64'd5);
        bus_write(ctrl_addr(R_START, 3), 64'd1);
        idle(3);
        check_reg("restart_acc", R_ACC, 3, 64'd0);
        check_reg("restart_status", R_STATUS, 3, 64'd1);
        check_reg("restart_cnt", R_START, 3, 64'd1);

        // Done set by stage 2 in the same cycle as a W1C: set wins.
        $display("[TB] set versus clear");
        do_reset();
        bus_write(ctrl_addr(R_START, 1), 64'd1);
        idle(1);
        bus_write(data_addr(1), 64'd7);
        bus_write(ctrl_addr(R_STATUS, 1), 64'd1);
        idle(2);
        check_reg("setwins_status", R_STATUS, 1, 64'd2);

        // Two channels interleaved back to back, then one word past the count.
        $display("[TB] interleaved channels");
        do_reset();
        bus_write(ctrl_addr(R_IRQ_EN, 0), 64'd1);
        bus_write(ctrl_addr(R_IRQ_EN, 1), 64'd1);
        bus_write(ctrl_addr(R_START, 0), 64'd3);
        bus_write(ctrl_addr(R_START, 1), 64'd3);
        for (int i = 0; i < 3; i++) begin
            bus_write(data_addr(0), 64'd1);
            bus_write(data_addr(1), 64'd1);
        end
        idle(3);
        checkOutput("il_irq_both", 64'(irq), 64'd1);
        check_reg("il_acc0", R_ACC, 0, 64'd3);
        check_reg("il_acc1", R_ACC, 1, 64'd3);
        check_reg("il_status0", R_STATUS, 0, 64'd2);
        check_reg("il_status1", R_STATUS, 1, 64'd2);
        bus_write(data_addr(0), 64'd1);
        idle(3);
        check_reg("il_extra_acc0", R_ACC, 0, 64'd3);
        check_reg("il_extra_cnt0", R_START, 0, 64'd0);
        bus_write(ctrl_addr(R_STATUS, 0), 64'd1);
        idle(3);
        checkOutput("il_irq_ch1_only", 64'(irq), 64'd1);
        bus_write(ctrl_addr(R_STATUS, 1), 64'd1);
        idle(3);
        checkOutput("il_irq_none", 64'(irq), 64'd0);

        // Randomized operations against the transaction-level model.
        $display("[TB] randomized operations");
        do_reset();
        for (int it = 0; it < 80; it++) begin
            ch   = int'($urandom_range(0, NUM_CH - 1));
            kind = int'($urandom_range(0, 9));
            if (kind <= 1) begin
                count = 32'($urandom_range(0, 3));
                bus_write(ctrl_addr(R_START, ch), 64'(count));
                m_cnt[ch] = count; m_acc[ch] = '0; m_busy[ch] = (count != 0);
                if (count == 0) m_done[ch] = 1;
            end else if (kind <= 6) begin
                d = {32'($urandom), 32'($urandom)};
                bus_write(data_addr(ch), d);
                if (m_busy[ch]) begin
                    m_acc[ch] = ref_add(m_acc[ch], ref_word(d));
                    m_cnt[ch] = m_cnt[ch] - 1;
                    if (m_cnt[ch] == 0) begin
                        m_busy[ch] = 0;
                        m_done[ch] = 1;
                    end
                end
            end else if (kind == 7) begin
                d = 64'($urandom_range(0, 1));
                bus_write(ctrl_addr(R_STATUS, ch), d);
                if (d[0]) m_done[ch] = 0;
            end else begin
                d = 64'($urandom_range(0, 1));
                bus_write(ctrl_addr(R_IRQ_EN, ch), d);
                m_en[ch] = d[0];
            end
            idle(3);
            checkOutput($sformatf("rnd%0d_irq", it), 64'(irq), 64'(ref_irq()));
            ch  = int'($urandom_range(0, NUM_CH - 1));
            sel = int'($urandom_range(0, 3));
            case (sel)
                R_START:  exp = 64'(m_cnt[ch]);
                R_STATUS: exp = 64'({m_done[ch], m_busy[ch]});
                R_IRQ_EN: exp = 64'(m_en[ch]);
                default:  exp = 64'(m_acc[ch]);
            endcase
            check_reg($sformatf("rnd%0d_sel%0d_ch%0d", it, sel, ch), sel, ch, exp);
        end

        // Reset in the middle of an active job with a word in flight.
        $display("[TB] reset mid-job");
        do_reset();
        bus_write(ctrl_addr(R_IRQ_EN, 1), 64'd1);
        bus_write(ctrl_addr(R_START, 1), 64'd0);
        bus_write(ctrl_addr(R_START, 0), 64'd5);
        idle(2);
        checkOutput("mid_irq_before", 64'(irq), 64'd1);
        bus_write(data_addr(0), 64'h1234);
        do_reset();
        idle(2);
        check_all_zero("midreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
